// File: rtl/imem_loader_pkg.sv
// Shared types and default sizes for the boot-time instruction-memory loader.
// The checksum feature is selected by IMEM_LOADER_CHECKSUM_EN in the loader itself.
package imem_loader_pkg;

  localparam int DEF_DEPTH    = 72;
  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_HOLD_CYC = 4;
  localparam int WORD_W       = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CSUM = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bundles for the loader: the upstream word stream and the instruction-memory
// write port. The loader is the stream slave and the write-port master.
interface imem_loader_if
  import imem_loader_pkg::*;
;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

interface imem_wr_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Streams an instruction image into imem from address 0 and keeps the core in
// reset until the image is complete. Optional checksum beat: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    in_bus,
  imem_wr_if.master       imem,
  output logic            cpu_reset,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = cnt_width(HOLD_CYC);
  localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [WORD_W-1:0]   wdata_reg, wdata_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                ready;
  logic                accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]   acc_reg, acc_next;
  logic [WORD_W-1:0]   csum_total;

  assign ready      = (state_reg == LOAD) || (state_reg == CSUM);
  assign csum_total = acc_reg + in_bus.in_data;
`else
  assign ready      = (state_reg == LOAD);
`endif

  // Ready depends only on the registered state, never on in_valid.
  assign accept = ready && in_bus.in_valid;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    hold_next  = hold_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_next   = acc_reg;
`endif

    case (state_reg)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_next = LOAD;
          count_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_next   = '0;
`endif
        end
      end

      LOAD: begin
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = count_reg[ADDR_W-1:0];
          wdata_next = in_bus.in_data;
          count_next = count_reg + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_next   = acc_reg + in_bus.in_data;
`endif
          if (in_bus.in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = HOLD;
`endif
            hold_next  = '0;
          end else if (count_reg == LAST_ADDR) begin
            // The last slot is still written; the image simply overran imem.
            state_next = ERR;
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          hold_next  = '0;
          state_next = (csum_total == '0) ? HOLD : ERR;
        end
      end
`endif

      HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = RUN;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      hold_reg  <= hold_next;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end
`endif

  assign in_bus.in_ready = ready;
  assign imem.imem_we    = we_reg;
  assign imem.imem_addr  = addr_reg;
  assign imem.imem_wdata = wdata_reg;

  // The core only leaves reset once the whole image is in and the hold time expired.
  assign cpu_reset    = (state_reg != RUN);
  assign done         = (state_reg == RUN);
  assign error        = (state_reg == ERR);
  assign words_loaded = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a queue-based reference model predicts every
// memory write and status edge, and a negedge monitor scores what the DUT does.
module tb_imem_loader;

  localparam int DEPTH    = 72;
  localparam int ADDR_W   = 7;
  localparam int HOLD_CYC = 4;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_RUN  = 2;
  localparam int M_ERR  = 3;

  typedef struct {
    int unsigned       cyc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            cpu_reset;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if in_bus();
  imem_wr_if #(.ADDR_W(ADDR_W)) imem();

  imem_loader #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_bus(in_bus),
    .imem(imem),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          model_state = M_IDLE;
  int          model_count = 0;
  logic [31:0] model_sum = '0;
  wr_t         exp_q[$];
  int unsigned done_q[$];
  int unsigned err_q[$];
  logic [31:0] img[$];
  wr_t         mon_e;
  logic        done_prev = 1'b0;
  logic        err_prev = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write and every rising done/error edge must match the model.
  always @(negedge clk) begin
    if (!reset) begin
      done_prev = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (imem.imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: got write addr 0x%0h data 0x%0h, expected no write", imem.imem_addr, imem.imem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("write_addr", 64'(imem.imem_addr), 64'(mon_e.addr));
          check("write_data", 64'(imem.imem_wdata), 64'(mon_e.data));
          $display("write addr=%0d data=%08h cycle=%0d", imem.imem_addr, imem.imem_wdata, cyc);
        end
      end
      if (done === 1'b1 && done_prev === 1'b0) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 at cycle %0d, expected done=0", cyc);
        end else begin
          check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
          check("cpu_reset_at_done", 64'(cpu_reset), 64'(0));
        end
      end
      if (error === 1'b1 && err_prev === 1'b0) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL error_unexpected: got error=1 at cycle %0d, expected error=0", cyc);
        end else begin
          check("error_cycle", 64'(cyc), 64'(err_q.pop_front()));
        end
      end
      done_prev = done;
      err_prev  = error;
    end
  end

  task automatic make_image(input int n);
    img.delete();
    for (int k = 0; k < n; k++) img.push_back($urandom());
  endtask

  // A start pulse from IDLE/RUN/ERR must put the loader into LOAD on the next cycle.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    model_state = M_BUSY;
    model_count = 0;
    model_sum   = '0;
    @(negedge clk);
    start = 1'b0;
    check("start_in_ready", 64'(in_bus.in_ready), 64'(1));
    check("start_cpu_reset", 64'(cpu_reset), 64'(1));
    check("start_done", 64'(done), 64'(0));
    check("start_error", 64'(error), 64'(0));
    check("start_words", 64'(words_loaded), 64'(0));
  endtask

  // Send img; vmode 0 = full rate, 1 = every other cycle, 2 = random.
  task automatic load_image(input bit give_last, input int vmode, input bit poke_start, input bit bad_csum);
    int          i;
    int          guard;
    bit          v;
    bit          overflow;
    int unsigned last_cyc;
    i = 0;
    guard = 0;
    overflow = 1'b0;
    last_cyc = 0;
    while (i < img.size() && guard < 4 * DEPTH + 50) begin
      @(negedge clk);
      guard++;
      case (vmode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      start = (poke_start && i == img.size() / 2) ? 1'b1 : 1'b0;
      in_bus.in_valid = v;
      in_bus.in_data  = v ? img[i] : $urandom();
      in_bus.in_last  = v ? (give_last && i == img.size() - 1) : 1'($urandom_range(0, 1));
      if (v && in_bus.in_ready === 1'b1) begin
        exp_q.push_back('{cyc: cyc + 1, addr: ADDR_W'(model_count), data: img[i]});
        model_count++;
        model_sum += img[i];
        last_cyc = cyc;
        if (!in_bus.in_last && model_count == DEPTH) begin
          overflow = 1'b1;
          err_q.push_back(cyc + 1);
          model_state = M_ERR;
          i = img.size();
        end else begin
          i++;
        end
      end
    end
    check("beats_accepted", 64'(i), 64'(img.size()));
    if (give_last && !overflow) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      guard = 0;
      v = 1'b0;
      while (!v && guard < 20) begin
        @(negedge clk);
        guard++;
        start = 1'b0;
        in_bus.in_valid = 1'b1;
        in_bus.in_data  = (32'd0 - model_sum) + (bad_csum ? 32'd1 : 32'd0);
        in_bus.in_last  = 1'($urandom_range(0, 1));
        if (in_bus.in_ready === 1'b1) begin
          v = 1'b1;
          if (bad_csum) begin
            err_q.push_back(cyc + 1);
            model_state = M_ERR;
          end else begin
            done_q.push_back(cyc + 1 + HOLD_CYC);
            model_state = M_RUN;
          end
        end
      end
      check("csum_accepted", 64'(v), 64'(1));
`else
      done_q.push_back(last_cyc + 1 + HOLD_CYC);
      model_state = M_RUN;
`endif
    end
    @(negedge clk);
    start = 1'b0;
    in_bus.in_valid = 1'b0;
    in_bus.in_last  = 1'b0;
  endtask

  task automatic wait_outcome();
    int n;
    n = 0;
    while ((exp_q.size() + done_q.size() + err_q.size()) != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("outcome_drained", 64'(exp_q.size() + done_q.size() + err_q.size()), 64'(0));
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(model_state == M_RUN));
    check({tag, "_error"}, 64'(error), 64'(model_state == M_ERR));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(model_state != M_RUN));
    check({tag, "_in_ready"}, 64'(in_bus.in_ready), 64'(0));
    check({tag, "_words"}, 64'(words_loaded), 64'(model_count));
    $display("image %s: words=%0d done=%0d error=%0d cpu_reset=%0d", tag, words_loaded, done, error, cpu_reset);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_bus.in_valid = 1'b0;
    in_bus.in_data  = '0;
    in_bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_bus.in_ready), 64'(0));
    check("rst_imem_we", 64'(imem.imem_we), 64'(0));
    check("rst_imem_addr", 64'(imem.imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(imem.imem_wdata), 64'(0));
    check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_words", 64'(words_loaded), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 64'(in_bus.in_ready), 64'(0));

    // Directed three-word program at full rate.
    pulse_start();
    img = '{32'h20080005, 32'h20090002, 32'h01095020};
    load_image(1'b1, 0, 1'b0, 1'b0);
    wait_outcome();
    check_status("directed");

    // Reload from RUN with random pacing.
    pulse_start();
    make_image(5);
    load_image(1'b1, 2, 1'b0, 1'b0);
    wait_outcome();
    check_status("reload");

    // Overflow: a full memory without in_last, then recovery.
    pulse_start();
    make_image(DEPTH);
    load_image(1'b0, 0, 1'b0, 1'b0);
    wait_outcome();
    check_status("overflow");
    pulse_start();
    make_image(2);
    load_image(1'b1, 0, 1'b0, 1'b0);
    wait_outcome();
    check_status("recover");

    // in_valid toggling every other cycle.
    pulse_start();
    make_image(9);
    load_image(1'b1, 1, 1'b0, 1'b0);
    wait_outcome();
    check_status("toggle");

    // Exactly DEPTH words with in_last on the final slot is a legal image.
    pulse_start();
    make_image(DEPTH);
    load_image(1'b1, 2, 1'b1, 1'b0);
    wait_outcome();
    check_status("full");

    for (int r = 0; r < 6; r++) begin
      pulse_start();
      make_image(int'($urandom_range(1, DEPTH)));
      load_image(1'b1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
      wait_outcome();
      check_status("random");
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    img = '{32'h00000001, 32'h00000002};
    load_image(1'b1, 0, 1'b0, 1'b0);
    wait_outcome();
    check_status("csum_good");
    pulse_start();
    img = '{32'h00000001, 32'h00000002};
    load_image(1'b1, 0, 1'b0, 1'b1);
    wait_outcome();
    check_status("csum_bad");
`endif

    // Reset in the middle of a load after 10 words.
    pulse_start();
    make_image(10);
    load_image(1'b0, 0, 1'b0, 1'b0);
    wait_outcome();
    check("midload_words", 64'(words_loaded), 64'(10));
    @(negedge clk);
    reset = 1'b0;
    model_state = M_IDLE;
    model_count = 0;
    #1;
    check("abort_in_ready", 64'(in_bus.in_ready), 64'(0));
    check("abort_cpu_reset", 64'(cpu_reset), 64'(1));
    check("abort_words", 64'(words_loaded), 64'(0));
    @(negedge clk);
    check("abort_hold_words", 64'(words_loaded), 64'(0));
    check("abort_hold_ready", 64'(in_bus.in_ready), 64'(0));
    reset = 1'b1;
    pulse_start();
    make_image(4);
    load_image(1'b1, 2, 1'b0, 1'b0);
    wait_outcome();
    check_status("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
